// File: rtl/spi_xfer_ctrl.sv
// SPI mode-0 word transmitter for an ILI9341-style display link.
// Words carry a D/C level; cs_n stays low across words until one is flagged last.
module spi_xfer_ctrl #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DIV    = 2,
  parameter int unsigned CS_GAP = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tx_valid,
  output logic              tx_ready,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_dc,
  input  logic              tx_last,
  output logic              sclk,
  output logic              mosi,
  output logic              cs_n,
  output logic              dc,
  output logic              busy,
  output logic              done
);

  localparam int unsigned CNT_MAX = (DIV > CS_GAP) ? DIV : CS_GAP;
  localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int unsigned BIT_W   = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(DIV - 1);
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(CS_GAP - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);

  typedef enum logic [2:0] {
    StIdle,
    StSetup,
    StShift,
    StDone,
    StHold,
    StGap
  } state_e;

  state_e            r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [BIT_W-1:0]  r_bit;
  logic              r_low;
  logic              r_last;
  logic [DATA_W-1:0] r_shreg;
  logic              r_sclk;
  logic              r_cs_n;
  logic              r_dc;
  logic              r_done;
  logic              w_accept;

  assign tx_ready = !rst && ((r_state == StIdle) || (r_state == StHold) ||
                             ((r_state == StDone) && !r_last));
  assign w_accept = tx_valid && tx_ready;

  // mosi is the shift register MSB, so it is a flop output and reads 0 once the register is cleared.
  assign mosi = r_shreg[DATA_W-1];
  assign sclk = r_sclk;
  assign cs_n = r_cs_n;
  assign dc   = r_dc;
  assign done = r_done;
  assign busy = (r_state != StIdle);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= StIdle;
      r_cnt   <= '0;
      r_bit   <= '0;
      r_low   <= 1'b0;
      r_last  <= 1'b0;
      r_shreg <= '0;
      r_sclk  <= 1'b0;
      r_cs_n  <= 1'b1;
      r_dc    <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        StIdle, StHold: begin
        end
        StSetup: begin
          if (r_cnt == DIV_LAST) begin
            r_state <= StShift;
            r_cnt   <= '0;
            r_bit   <= '0;
            r_low   <= 1'b0;
            r_sclk  <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        StShift: begin
          if (r_cnt != DIV_LAST) begin
            r_cnt <= r_cnt + 1'b1;
          end else if (!r_low) begin
            r_cnt  <= '0;
            r_low  <= 1'b1;
            r_sclk <= 1'b0;
          end else if (r_bit == BIT_LAST) begin
            r_state <= StDone;
            r_cnt   <= '0;
            r_done  <= 1'b1;
          end else begin
            r_cnt   <= '0;
            r_low   <= 1'b0;
            r_bit   <= r_bit + 1'b1;
            r_shreg <= r_shreg << 1;
            r_sclk  <= 1'b1;
          end
        end
        StDone: begin
          if (r_last) begin
            r_state <= StGap;
            r_cnt   <= '0;
            r_cs_n  <= 1'b1;
            r_shreg <= '0;
          end else if (!w_accept) begin
            r_state <= StHold;
            r_shreg <= '0;
          end
        end
        StGap: begin
          if (r_cnt == GAP_LAST) begin
            r_state <= StIdle;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: begin
          r_state <= StIdle;
          r_cs_n  <= 1'b1;
          r_sclk  <= 1'b0;
          r_shreg <= '0;
        end
      endcase

      // Acceptance is only possible in IDLE, HOLD or non-last DONE; it overrides the moves above.
      if (w_accept) begin
        r_state <= StSetup;
        r_cnt   <= '0;
        r_shreg <= tx_data;
        r_dc    <= tx_dc;
        r_last  <= tx_last;
        r_cs_n  <= 1'b0;
        r_sclk  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_spi_xfer_ctrl.sv
// Bench for spi_xfer_ctrl: vector table plus hand sequences, scoreboard on done pulses.
// A second instance covers the 16-bit, DIV=1 configuration.
module tb_spi_xfer_ctrl;

  localparam int LAT0 = 2 * (2 * 8 + 1) + 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        tx_valid, tx_ready, tx_dc, tx_last;
  logic [7:0]  tx_data;
  logic        sclk0, mosi0, cs_n0, dc0, busy0, done0;
  logic        tx1_valid, tx1_ready, tx1_dc, tx1_last;
  logic [15:0] tx1_data;
  logic        sclk1, mosi1, cs_n1, dc1, busy1, done1;

  spi_xfer_ctrl #(.DATA_W(8), .DIV(2), .CS_GAP(2)) u_dut0 (
    .clk      (clk),
    .rst      (rst),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .tx_data  (tx_data),
    .tx_dc    (tx_dc),
    .tx_last  (tx_last),
    .sclk     (sclk0),
    .mosi     (mosi0),
    .cs_n     (cs_n0),
    .dc       (dc0),
    .busy     (busy0),
    .done     (done0)
  );

  spi_xfer_ctrl #(.DATA_W(16), .DIV(1), .CS_GAP(2)) u_dut1 (
    .clk      (clk),
    .rst      (rst),
    .tx_valid (tx1_valid),
    .tx_ready (tx1_ready),
    .tx_data  (tx1_data),
    .tx_dc    (tx1_dc),
    .tx_last  (tx1_last),
    .sclk     (sclk1),
    .mosi     (mosi1),
    .cs_n     (cs_n1),
    .dc       (dc1),
    .busy     (busy1),
    .done     (done1)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests  = 0;
  int errors = 0;

  typedef struct {
    logic [7:0] bits;
    logic       dc;
    int         cyc;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    logic [7:0] data;
    logic       dc;
    logic       last;
    int         gap;
    logic [7:0] exp_bits;
    int         exp_lat;
  } vec_t;
  vec_t vecs[8];

  int         rises = 0;
  int         cs_hi = 0;
  logic       prev_sclk = 1'b0;
  logic [7:0] cap = '0;
  int         nbits = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #2;
  endtask

  task automatic wait_cyc(input int target);
    while (cyc < target) tick();
  endtask

  task automatic wait_idle();
    int w = 0;
    while (busy0 && w < 300) begin
      tick();
      w++;
    end
    chk("idle_reached", busy0, 0);
  endtask

  // Offers a word until accepted; optionally scrambles the inputs while tx_ready is low.
  task automatic send(input logic [7:0] d, input logic dcv, input logic lastv, input bit toggle,
                      input logic [7:0] eb, input int lat, output int acc);
    int w = 0;
    tx_valid = 1'b1;
    tx_data  = d;
    tx_dc    = dcv;
    tx_last  = lastv;
    while (!tx_ready && w < 300) begin
      if (toggle) begin
        tx_data = 8'($urandom);
        tx_dc   = 1'($urandom);
        tx_last = 1'($urandom);
      end
      tick();
      w++;
    end
    tx_data = d;
    tx_dc   = dcv;
    tx_last = lastv;
    if (!tx_ready) chk("accept_timeout", 0, 1);
    acc = cyc;
    sb.push_back('{eb, dcv, cyc + lat});
    tick();
    tx_valid = 1'b0;
  endtask

  // Monitor: captures mosi at each sclk rise and checks every done pulse against the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      nbits     = 0;
      cap       = '0;
      prev_sclk = 1'b0;
    end else begin
      if (sclk0 && !prev_sclk) begin
        cap = {cap[6:0], mosi0};
        nbits++;
        rises++;
      end
      prev_sclk = sclk0;
      if (cs_n0) cs_hi++;
      if (done0) begin
        if (sb.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          e = sb.pop_front();
          chk("done_cycle", cyc, e.cyc);
          chk("mosi_bits", cap, e.bits);
          chk("bit_count", nbits, 8);
          chk("dc_level", dc0, e.dc);
        end
        nbits = 0;
        cap   = '0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d errors so far", errors);
    $fatal(1);
  end

  initial begin
    int a, a1, a2, a3, e, h0, r0, w, viol;
    int n1, lr, bad, dcy;
    logic [15:0] cap1;
    logic p1;

    vecs[0] = '{8'h2A, 1'b0, 1'b1, 0,  8'h2A, LAT0};
    vecs[1] = '{8'hFF, 1'b1, 1'b1, 0,  8'hFF, LAT0};
    vecs[2] = '{8'h00, 1'b0, 1'b0, 40, 8'h00, LAT0};
    vecs[3] = '{8'h81, 1'b1, 1'b1, 0,  8'h81, LAT0};
    vecs[4] = '{8'h55, 1'b1, 1'b0, 0,  8'h55, LAT0};
    vecs[5] = '{8'hAA, 1'b0, 1'b0, 0,  8'hAA, LAT0};
    vecs[6] = '{8'h01, 1'b1, 1'b1, 0,  8'h01, LAT0};
    vecs[7] = '{8'h80, 1'b1, 1'b1, 0,  8'h80, LAT0};

    rst       = 1'b1;
    tx_valid  = 1'b0;
    tx_data   = '0;
    tx_dc     = 1'b0;
    tx_last   = 1'b0;
    tx1_valid = 1'b0;
    tx1_data  = '0;
    tx1_dc    = 1'b0;
    tx1_last  = 1'b0;

    repeat (3) tick();
    chk("rst_cs_n", cs_n0, 1);
    chk("rst_sclk", sclk0, 0);
    chk("rst_mosi", mosi0, 0);
    chk("rst_dc", dc0, 0);
    chk("rst_done", done0, 0);
    chk("rst_busy", busy0, 0);
    chk("rst_ready", tx_ready, 0);
    chk("rst_cs_n_dut1", cs_n1, 1);
    rst = 1'b0;
    #1;
    chk("ready_after_rst", tx_ready, 1);
    tick();

    // Single last word: timing of cs_n and tx_ready around the gap.
    send(8'h2A, 1'b0, 1'b1, 1'b0, 8'h2A, LAT0, a);
    chk("cs_n_low_setup", cs_n0, 0);
    chk("busy_setup", busy0, 1);
    chk("ready_setup", tx_ready, 0);
    h0 = cs_hi;
    wait_cyc(a + LAT0);
    chk("cs_n_low_word", cs_hi - h0, 0);
    tick();
    chk("cs_n_gap1", cs_n0, 1);
    chk("ready_gap1", tx_ready, 0);
    tick();
    chk("cs_n_gap2", cs_n0, 1);
    chk("ready_gap2", tx_ready, 0);
    tick();
    chk("ready_idle", tx_ready, 1);
    chk("busy_idle", busy0, 0);
    chk("cs_n_idle", cs_n0, 1);

    // Three back-to-back words; the third offer scrambles inputs while the second shifts.
    wait_idle();
    send(8'h2C, 1'b0, 1'b0, 1'b0, 8'h2C, LAT0, a1);
    r0 = rises;
    h0 = cs_hi;
    send(8'hF8, 1'b1, 1'b0, 1'b0, 8'hF8, LAT0, a2);
    chk("b2b_gap12", a2 - a1, LAT0);
    send(8'h00, 1'b1, 1'b1, 1'b1, 8'h00, LAT0, a3);
    chk("b2b_gap23", a3 - a2, LAT0);
    wait_cyc(a1 + 3 * LAT0);
    chk("sclk_rises_3w", rises - r0, 24);
    chk("cs_n_low_3w", cs_hi - h0, 0);
    wait_idle();

    for (int i = 0; i < 8; i++) begin
      send(vecs[i].data, vecs[i].dc, vecs[i].last, 1'b0, vecs[i].exp_bits, vecs[i].exp_lat, a);
      repeat (vecs[i].gap) tick();
    end
    wait_idle();
    chk("dc_held_idle", dc0, vecs[7].dc);

    // HOLD between words with tx_valid low.
    send(8'h5A, 1'b1, 1'b0, 1'b0, 8'h5A, LAT0, a);
    wait_cyc(a + LAT0);
    r0   = rises;
    viol = 0;
    repeat (10) begin
      tick();
      if (cs_n0 !== 1'b0 || sclk0 !== 1'b0 || mosi0 !== 1'b0 || tx_ready !== 1'b1) viol++;
    end
    chk("hold_pins", viol, 0);
    chk("hold_no_sclk", rises - r0, 0);
    e = cyc;
    send(8'h81, 1'b0, 1'b1, 1'b0, 8'h81, LAT0, a);
    chk("hold_accept_first", a, e);
    wait_idle();

    // Reset during bit 4 aborts the word.
    send(8'hC3, 1'b1, 1'b0, 1'b0, 8'hC3, LAT0, a);
    r0 = rises;
    w  = 0;
    while (rises - r0 < 5 && w < 200) begin
      tick();
      w++;
    end
    chk("bit4_reached", rises - r0, 5);
    rst = 1'b1;
    tick();
    sb.delete();
    chk("abort_cs_n", cs_n0, 1);
    chk("abort_sclk", sclk0, 0);
    chk("abort_mosi", mosi0, 0);
    chk("abort_busy", busy0, 0);
    chk("abort_done", done0, 0);
    chk("abort_dc", dc0, 0);
    rst = 1'b0;
    #1;
    chk("ready_after_abort", tx_ready, 1);
    r0 = rises;
    h0 = cs_hi;
    repeat (40) tick();
    chk("no_resume_sclk", rises - r0, 0);
    chk("no_resume_cs", cs_hi - h0, 40);

    // 16-bit word at DIV=1 on the second instance.
    tx1_valid = 1'b1;
    tx1_data  = 16'hA5C3;
    tx1_dc    = 1'b1;
    tx1_last  = 1'b1;
    chk("dut1_ready", tx1_ready, 1);
    a = cyc;
    tick();
    tx1_valid = 1'b0;
    tx1_data  = 16'h0000;
    n1   = 0;
    cap1 = '0;
    p1   = 1'b0;
    lr   = -1;
    bad  = 0;
    dcy  = -1;
    repeat (40) begin
      if (sclk1 && !p1) begin
        cap1 = {cap1[14:0], mosi1};
        n1++;
        if (lr >= 0 && cyc - lr != 2) bad++;
        lr = cyc;
      end
      p1 = sclk1;
      if (done1) dcy = cyc;
      tick();
    end
    chk("dut1_bits", cap1, 16'hA5C3);
    chk("dut1_rises", n1, 16);
    chk("dut1_sclk_period", bad, 0);
    chk("dut1_done_cycle", dcy, a + 34);
    chk("dut1_dc", dc1, 1);
    chk("dut1_busy_end", busy1, 0);

    wait_idle();
    chk("sb_drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule

// File: doc/spi_xfer_ctrl.md
SPI_XFER_CTRL -- requirements
Module: spi_xfer_ctrl

Interface
REQ-001 SHALL have parameter DATA_W, default 8, bits per word (legal 1..32).
REQ-002 SHALL have parameter DIV, default 2, clk cycles per SCLK half-period (legal 1..255).
REQ-003 SHALL have parameter CS_GAP, default 2, clk cycles cs_n held high after a last word (legal 1..15).
REQ-004 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-005 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-006 SHALL have port tx_valid  input  1  word offered.
REQ-007 SHALL have port tx_ready  output  1  word accepted when tx_valid and tx_ready are both high.
REQ-008 SHALL have port tx_data  input  DATA_W  word, transmitted MSB first.
REQ-009 SHALL have port tx_dc  input  1  ILI9341 D/C level for this word (0 = command, 1 = data).
REQ-010 SHALL have port tx_last  input  1  release cs_n after this word.
REQ-011 SHALL have ports sclk, mosi, cs_n, dc  output  1 each  registered SPI mode-0 pins plus D/C.
REQ-012 SHALL have port busy  output  1  high whenever state is not IDLE.
REQ-013 SHALL have port done  output  1  one-cycle pulse per completed word.

Function
REQ-014 SHALL implement states IDLE, SETUP, SHIFT, DONE, HOLD, GAP.
REQ-015 SHALL drive tx_ready combinationally: 1 in IDLE, in HOLD, and in DONE when the latched last = 0; 0 otherwise and while rst is high.
REQ-016 SHALL, on acceptance, latch tx_data into the shift register, tx_dc into dc and tx_last into last; enter SETUP next cycle.
REQ-017 SHALL ignore tx_data, tx_dc and tx_last when no acceptance occurs; mosi/dc SHALL NOT follow input changes mid-word.
REQ-018 SETUP: DIV cycles; cs_n = 0, sclk = 0, mosi = word MSB.
REQ-019 SHIFT: per bit, DIV cycles sclk = 1, then DIV cycles sclk = 0; at the end of each low phase, shift left and present the next bit on mosi.
REQ-020 SHALL leave SHIFT for DONE after the low phase of bit DATA_W-1; DATA_W rising sclk edges per word, exactly.
REQ-021 Latency: done SHALL be high exactly DIV*(2*DATA_W+1)+1 cycles after the acceptance cycle.
REQ-022 DONE: 1 cycle; done = 1, cs_n = 0, sclk = 0.
REQ-023 In DONE with last = 0: an acceptance SHALL go straight to SETUP with cs_n kept low (back-to-back, no idle cycle); with no acceptance the next state SHALL be HOLD.
REQ-024 HOLD: cs_n = 0, sclk = 0, mosi = 0; wait indefinitely; an acceptance SHALL go to SETUP.
REQ-025 In DONE with last = 1: SHALL go to GAP; GAP drives cs_n = 1, tx_ready = 0 for CS_GAP cycles, then IDLE.
REQ-026 IDLE: cs_n = 1, sclk = 0, mosi = 0; dc holds its last latched value.
REQ-027 sclk, mosi, cs_n and dc SHALL come straight from flops (glitch-free, no combinational clock gating).
REQ-028 Counters SHALL be sized $clog2 of their range and SHALL never wrap inside a word.

Reset
REQ-029 While rst = 1 at a clk edge: state = IDLE, cs_n = 1, sclk = 0, mosi = 0, dc = 0, done = 0, busy = 0, counters = 0.
REQ-030 Reset mid-word SHALL abort on the next edge: no done pulse, cs_n = 1, and no partial-word resumption after release.
REQ-031 tx_ready SHALL be 1 in the first cycle after rst deasserts.

Verification
REQ-032 DATA_W = 8, DIV = 2, CS_GAP = 2; accept 0x2A, dc = 0, last = 1 at cycle 0 -> cs_n low from cycle 1, mosi 0,0,1,0,1,0,1,0 at the 8 rising sclk edges, dc = 0, done at cycle 35, cs_n high on cycles 36-37, tx_ready = 1 at cycle 38.
REQ-033 Same configuration; 3 words 0x2C, 0xF8, 0x00 with tx_valid held, last only on the third -> cs_n low continuously, done at cycles 35, 70, 105, 24 sclk rising edges total.
REQ-034 Word with last = 0, then tx_valid low for 10 cycles -> HOLD: cs_n = 0, sclk = 0, tx_ready = 1, no sclk edges; next word accepted on its first valid cycle and done 35 cycles later.
REQ-035 rst pulsed during bit 4 of a word -> next edge: cs_n = 1, sclk = 0, mosi = 0, busy = 0; no done pulse; tx_ready = 1 after release.
REQ-036 DATA_W = 16, DIV = 1; accept 0xA5C3 -> sclk period 2 cycles, mosi bits 1010010111000011 MSB first, done at cycle 34.
REQ-037 tx_valid high and tx_data toggling every cycle during SHIFT -> tx_ready = 0 and mosi bit sequence unchanged from the accepted word.
